mem_port_arbiter: RTL

//   Sits directly upstream of the RV32I memory block: merges the core's instruction-fetch (IF) and

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/ls_align_check.sv | 24 ++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
// FSM states and RV32I load/store funct3 encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_DATA,
    LS_DATA,
    LS_ACK
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ls_align_check.sv
// Flags load/store accesses that must not reach memory:
// reserved funct3, unsigned stores, misaligned half/word.
module ls_align_check
  import mem_arb_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       we,
  input  logic [1:0] addr,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      funct3 == F3_B:  illegal = 1'b0;
      funct3 == F3_BU: illegal = we;
      funct3 == F3_H:  illegal = addr[0];
      funct3 == F3_HU: illegal = we | addr[0];
      funct3 == F3_W:  illegal = |addr;
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges fetch and load/store traffic onto one memory port,
// sequencing the 1-cycle read latency with a starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit LS_PRIORITY  = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  state_t        state;
  logic [31:0]   raddr_q;
  logic [31:0]   waddr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   ls_rdata_q;
  logic [2:0]    f3_q;
  logic          err_q;
  logic [CW-1:0] if_cnt;
  logic [CW-1:0] ls_cnt;

  logic        illegal;
  logic        idle;
  logic        if_starved;
  logic        ls_starved;
  logic        pick_ls;
  logic        if_win;
  logic        ls_win;
  logic        st_ok;
  logic [31:0] if_word;

  ls_align_check u_chk (
    .funct3  (ls_funct3),
    .we      (ls_we),
    .addr    (ls_addr[1:0]),
    .illegal (illegal)
  );

  assign idle       = rst_n && (state == IDLE);
  assign if_starved = (if_cnt == LIM);
  assign ls_starved = (ls_cnt == LIM);
  assign if_word    = if_addr & ~32'h3;

  // A starved requester overrides the static priority.
  always_comb begin
    pick_ls = LS_PRIORITY;
    unique case (1'b1)
      if_starved && !ls_starved: pick_ls = 1'b0;
      ls_starved && !if_starved: pick_ls = 1'b1;
      default:                   pick_ls = LS_PRIORITY;
    endcase
  end

  assign if_win = idle && if_req && !(ls_req && pick_ls);
  assign ls_win = idle && ls_req && !(if_req && !pick_ls);
  assign st_ok  = ls_win && ls_we && !illegal;

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign mem_write = st_ok;

  assign mem_read_address =
    if_win ? if_word :
    ls_win ? ls_addr : raddr_q;
  assign mem_funct3 =
    if_win ? F3_W :
    ls_win ? ls_funct3 : f3_q;
  assign mem_write_address = st_ok ? ls_addr  : waddr_q;
  assign mem_write_data    = st_ok ? ls_wdata : wdata_q;

  assign if_rvalid = (state == IF_DATA);
  assign ls_rvalid = (state == LS_DATA) || (state == LS_ACK);
  assign ls_err    = (state == LS_ACK) && err_q;

  assign if_rdata = if_rvalid ? mem_read_data : if_rdata_q;
  assign ls_rdata =
    (state == LS_DATA) ? mem_read_data :
    (state == LS_ACK)  ? 32'h0 : ls_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_cnt     <= '0;
      ls_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_win) begin
            raddr_q <= if_word;
            f3_q    <= F3_W;
            state   <= IF_DATA;
          end else if (ls_win) begin
            raddr_q <= ls_addr;
            f3_q    <= ls_funct3;
            err_q   <= illegal;
            if (st_ok) begin
              waddr_q <= ls_addr;
              wdata_q <= ls_wdata;
            end
            state <= (ls_we || illegal) ? LS_ACK : LS_DATA;
          end
        end
        IF_DATA: begin
          if_rdata_q <= mem_read_data;
          state      <= IDLE;
        end
        LS_DATA: begin
          ls_rdata_q <= mem_read_data;
          state      <= IDLE;
        end
        LS_ACK: begin
          ls_rdata_q <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Loss counters only move in IDLE since wins are gated by idle.
      if (if_win)
        if_cnt <= '0;
      else if (if_req && ls_win && !if_starved)
        if_cnt <= if_cnt + 1'b1;

      if (ls_win)
        ls_cnt <= '0;
      else if (ls_req && if_win && !ls_starved)
        ls_cnt <= ls_cnt + 1'b1;
    end
  end

endmodule
